// File: rtl/midi_uart_rx_pkg.sv
// Shared definitions for the MIDI serial receiver: FSM encodings, line rate,
// and status-word bit positions used by the processor I/O map.
package midi_uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    localparam int MIDI_BAUD = 31250;

    localparam int STAT_EMPTY_BIT     = 8;
    localparam int STAT_OVERFLOW_BIT  = 9;
    localparam int STAT_FRAME_ERR_BIT = 10;

endpackage

// File: rtl/midi_uart_rx_if.sv
// Processor-facing side of the MIDI receiver: read strobe, head byte, occupancy
// and sticky status. master = processor, slave = receiver.
interface midi_uart_rx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic          clr_flags;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          frame_err;

    modport master (
        output rd_en, clr_flags,
        input  rd_data, empty, full, count, overflow, frame_err
    );

    modport slave (
        input  rd_en, clr_flags,
        output rd_data, empty, full, count, overflow, frame_err
    );
endinterface

// File: rtl/midi_uart_rx_sync_fifo.sv
// First-word-fall-through circular FIFO; head is combinational, zero when empty.
// A push into a full FIFO succeeds only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       push_dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_CNT);
    assign count        = count_q;
    assign head         = empty ? '0 : mem_q[rd_ptr_q];
    assign do_pop       = pop && !empty;
    assign do_push      = push && (!full || do_pop);
    assign push_dropped = push && !do_push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 receiver: synchronizer, deframing FSM, byte FIFO and sticky flags.
// Byte visible SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the start edge.
module midi_uart_rx
    import midi_uart_rx_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = MIDI_BAUD,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           midi_in,
    midi_uart_rx_if.slave  bus
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int TW  = $clog2(CPB);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CPB/2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CPB - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   armed_q, armed_d;
    logic                   rxs;
    rx_state_e              state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   push_q, push_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;
    logic                   fe_set;
    logic                   push_dropped;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], midi_in};
    assign rxs    = sync_q[SYNC_STAGES-1];

    // The synchronizer resets high, so a start is only trusted once a real
    // post-reset high has propagated through it.
    assign fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
    assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & rxs);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        fe_set    = 1'b0;
        unique case (state_q)
            ST_IDLE: if (armed_q && !rxs) begin
                tick_d  = HALF_LOAD;
                state_d = ST_START;
            end
            ST_START: if (tick_q != '0) begin
                tick_d = tick_q - TW'(1);
            end else if (rxs) begin
                state_d = ST_IDLE;
            end else begin
                tick_d    = FULL_LOAD;
                bit_idx_d = '0;
                state_d   = ST_DATA;
            end
            ST_DATA: if (tick_q != '0) begin
                tick_d = tick_q - TW'(1);
            end else begin
                shift_d[bit_idx_q] = rxs;
                tick_d             = FULL_LOAD;
                bit_idx_d          = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) state_d = ST_STOP;
            end
            ST_STOP: if (tick_q != '0) begin
                tick_d = tick_q - TW'(1);
            end else if (rxs) begin
                push_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                fe_set  = 1'b1;
                state_d = ST_BREAK;
            end
            ST_BREAK: if (rxs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A set event in the same cycle as clr_flags wins.
    assign frame_err_d = fe_set       | (frame_err_q & ~bus.clr_flags);
    assign overflow_d  = push_dropped | (overflow_q  & ~bus.clr_flags);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q      <= '1;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push         (push_q),
        .push_data    (shift_q),
        .pop          (bus.rd_en),
        .head         (bus.rd_data),
        .empty        (bus.empty),
        .full         (bus.full),
        .count        (bus.count),
        .push_dropped (push_dropped)
    );

    assign bus.frame_err = frame_err_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_midi_uart_rx.sv
// Bench for midi_uart_rx at 16 clocks per bit: directed frames with a
// scoreboard of expected bytes checked by an independent pop monitor.
module tb_midi_uart_rx;
    import midi_uart_rx_pkg::*;

    localparam int CPB = 16;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic midi_in = 1'b1;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q [$];

    midi_uart_rx_if #(.FIFO_DEPTH(16)) bus ();

    midi_uart_rx #(
        .CLK_HZ      (500000),
        .BAUD        (31250),
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .midi_in (midi_in),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        midi_in = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            midi_in = d[i];
            cyc(CPB);
        end
        midi_in = stop;
        cyc(CPB);
    endtask

    task automatic send_exp(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b1);
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        cyc(1);
        bus.rd_en = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_clr();
        bus.clr_flags = 1'b1;
        cyc(1);
        bus.clr_flags = 1'b0;
    endtask

    task automatic wait_count(input int n, input string name);
        int k = 0;
        while (int'(bus.count) != n && k < 400) begin
            cyc(1);
            k++;
        end
        check(name, 32'(bus.count), 32'(n));
    endtask

    // Pop monitor: every accepted pop must match the oldest expected byte.
    always @(negedge clock) begin
        if (!reset && bus.rd_en && !bus.empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%02h, nothing expected", bus.rd_data);
            end else begin
                check("pop_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bus.rd_en     = 1'b0;
        bus.clr_flags = 1'b0;

        cyc(3);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_count", 32'(bus.count), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_frame_err", 32'(bus.frame_err), 0);
        reset = 1'b0;
        cyc(8);

        // 1: single byte
        send_exp(8'h90);
        wait_count(1, "t1_count");
        check("t1_empty", 32'(bus.empty), 0);
        check("t1_rd_data", 32'(bus.rd_data), 32'h90);
        check("t1_flags", {30'd0, bus.overflow, bus.frame_err}, 0);
        pop_one();
        check("t1_empty_after", 32'(bus.empty), 1);
        check("t1_rd_data_after", 32'(bus.rd_data), 0);

        // 2: back-to-back frames
        send_exp(8'h90);
        send_exp(8'h3C);
        send_exp(8'h7F);
        wait_count(3, "t2_count");
        repeat (3) pop_one();
        check("t2_empty", 32'(bus.empty), 1);

        // 3: short glitch rejected
        midi_in = 1'b0;
        cyc(4);
        midi_in = 1'b1;
        cyc(40);
        check("t3_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("t3_count", 32'(bus.count), 0);
        check("t3_frame_err", 32'(bus.frame_err), 0);
        send_exp(8'h45);
        wait_count(1, "t3_count_45");
        pop_one();

        // 4: framing error followed by a long break
        send_frame(8'h55, 1'b0);
        check("t4_frame_err", 32'(bus.frame_err), 1);
        check("t4_count", 32'(bus.count), 0);
        cyc(100 * CPB);
        check("t4_frame_err_break", 32'(bus.frame_err), 1);
        check("t4_count_break", 32'(bus.count), 0);
        check("t4_state_break", 32'(dut.state_q), 32'(ST_BREAK));
        midi_in = 1'b1;
        cyc(2 * CPB);
        pulse_clr();
        check("t4_frame_err_clr", 32'(bus.frame_err), 0);
        send_exp(8'hF8);
        wait_count(1, "t4_count_f8");
        pop_one();
        check("t4_frame_err_end", 32'(bus.frame_err), 0);

        // 5a: overfill by one byte
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        cyc(4);
        check("t5_count", 32'(bus.count), 16);
        check("t5_full", 32'(bus.full), 1);
        check("t5_overflow", 32'(bus.overflow), 1);
        repeat (16) pop_one();
        check("t5_empty", 32'(bus.empty), 1);
        pulse_clr();
        check("t5_overflow_clr", 32'(bus.overflow), 0);

        // 5b: refill, pop on the same cycle the 17th byte is pushed
        for (int i = 0; i < 16; i++) send_exp(8'(i));
        exp_q.push_back(8'h10);
        fork
            send_frame(8'h10, 1'b1);
            begin
                cyc(155);
                bus.rd_en = 1'b1;
                cyc(1);
                bus.rd_en = 1'b0;
            end
        join
        cyc(4);
        check("t5b_count", 32'(bus.count), 16);
        check("t5b_overflow", 32'(bus.overflow), 0);
        repeat (16) pop_one();
        check("t5b_empty", 32'(bus.empty), 1);

        // 6: reset mid-frame discards both held and partial bytes
        send_frame(8'h12, 1'b1);
        wait_count(1, "t6_pre_count");
        fork
            send_frame(8'hAA, 1'b1);
            begin
                cyc(4 * CPB + 8);
                reset = 1'b1;
                cyc(96);
                reset = 1'b0;
            end
        join
        cyc(4);
        check("t6_count", 32'(bus.count), 0);
        check("t6_empty", 32'(bus.empty), 1);
        check("t6_rd_data", 32'(bus.rd_data), 0);
        send_exp(8'hB0);
        wait_count(1, "t6_count_b0");
        pop_one();
        check("t6_empty_end", 32'(bus.empty), 1);

        cyc(4);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/midi_uart_rx.md
Name: midi_uart_rx

Overview:
- Serial MIDI input front end; the stage directly upstream of the processor's memory-mapped I/O.
- Receives the 31250-baud MIDI serial line (8N1, LSB first) and deframes bytes.
- Buffers received bytes in a first-word-fall-through FIFO; the processor pops them through a simple read strobe.
- Reports FIFO occupancy plus sticky overflow and framing-error flags for polling.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 31250, serial bit rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer division; must be ≥ 4).
- FIFO_DEPTH, 16, byte entries; power of two, ≥ 2.
- SYNC_STAGES, 2, input synchronizer flop count, ≥ 2.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- midi_in  in  1  asynchronous serial line; idle high.
- rd_en  in  1  pop the head byte this cycle; ignored when empty.
- rd_data  out  8  head byte; 8'h00 when empty.
- empty  out  1  FIFO holds no bytes.
- count  out  $clog2(FIFO_DEPTH)+1  number of bytes held.
- overflow  out  1  sticky: a completed byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: a stop bit was sampled low.
- clr_flags  in  1  clears overflow and frame_err next edge.

Behaviour:
Clock and reset:
- One clock; reset is synchronous and active-high.
- Reset values: synchronizer flops = 1, state = IDLE, bit counter = 0, count = 0, empty = 1, rd_data = 8'h00, overflow = 0, frame_err = 0. FIFO storage is not reset.
- Reset asserted mid-byte abandons the byte. Receiving restarts only on a fresh falling edge seen after reset deasserts.

Receive FSM (operates on the synchronized line `rxs`; one shared down-counter `tick`):
- IDLE: when rxs = 0, load tick = CLKS_PER_BIT/2 − 1 and go to START.
- START: when tick = 0, sample rxs. If 1, treat as a glitch and return to IDLE. If 0, load tick = CLKS_PER_BIT − 1, set bit index = 0, go to DATA.
- DATA: when tick = 0, shift rxs into shift[bit index] (LSB first) and reload tick. After bit 7, go to STOP.
- STOP: when tick = 0, sample rxs.
  - If 1: push the byte and return to IDLE.
  - If 0: set frame_err, discard the byte, go to BREAK.
- BREAK: wait until rxs = 1, then go to IDLE. A held-low line (MIDI break) therefore yields exactly one frame_err and no bytes.

Latency:
- Sampling points fall near bit centres, offset by the synchronizer delay.
- The push is registered on the stop-sample edge; empty falls and count increments on the following cycle.
- Total from the midi_in falling edge: SYNC_STAGES + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles (±1).

FIFO:
- Circular buffer; pointer width = $clog2(FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH with no special case.
- rd_data is combinational from the head entry, gated to 0 when empty.
- rd_en while empty has no effect.
- Push while not full: store the byte; count +1.
- Push while full and rd_en = 0: drop the byte, set overflow; count and contents unchanged.
- Push while full with rd_en = 1 in the same cycle: pop and push both occur; count stays FIFO_DEPTH; no overflow.
- Push and pop while partially full: count unchanged; order preserved.

Flags:
- Sticky flags hold until clr_flags or reset.
- If clr_flags and a new set event occur in the same cycle, the set wins (flag = 1).

Decomposition:
- Shared header midi_defs.vh holds:
  - FSM state encodings: IDLE = 0, START = 1, DATA = 2, STOP = 3, BREAK = 4.
  - MIDI_BAUD = 31250.
  - Status-word bit positions for the processor I/O map: bit 8 = empty, bit 9 = overflow, bit 10 = frame_err.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; ports push, push_data, pop, head, empty, full, count, push_dropped). It owns all full/empty and simultaneous push/pop rules.
- The FSM, synchronizer, and flags stay in midi_uart_rx.

Test Plan (CLK_HZ = 500000, BAUD = 31250 → CLKS_PER_BIT = 16; FIFO_DEPTH = 16):
1. Serialize 0x90 → within 16·9.5 + 4 cycles: empty = 0, count = 1, rd_data = 0x90, flags 0. One rd_en pulse → empty = 1, rd_data = 0x00.
2. Back-to-back 0x90, 0x3C, 0x7F with no idle gap → count = 3. Three rd_en pulses return 0x90, 0x3C, 0x7F in order, then empty = 1.
3. midi_in low for 4 cycles, then high → state returns to IDLE, count = 0, frame_err = 0. Then send 0x45 → received correctly.
4. 0x55 sent with a low stop bit → frame_err = 1, count = 0. Hold the line low for 100 bit times → no further bytes, frame_err still 1. Release and pulse clr_flags → frame_err = 0; the next byte 0xF8 is received.
5. Send bytes 0x00..0x10 (17 bytes) with no reads → count = 16, overflow = 1, pops yield 0x00..0x0F. Repeat the fill, then assert rd_en exactly on the 17th push cycle → count = 16, overflow unchanged, the 17th byte appears last.
6. Assert reset midway through the data bits of 0xAA → count = 0, empty = 1, no partial byte. Subsequent 0xB0 is received intact.
